// File: rtl/interrupt_unit.sv
// interrupt_unit: interrupt controller for the microcoded CPU.
// Gates the active-low external request with an enable flag and latches it as
// a pending interrupt (fi). It also tracks entry to and exit from the interrupt
// microprogram on nirqs. The state is three flops: ie, pend and irqs.
//
// Input semantics: every control input is an active-low level that is sampled
// on the rising clock edge. A low level held for k edges acts k times. The
// microcode asserts END# for exactly one clock because END# toggles irqs.
module interrupt_unit (
   input  logic clk,
   input  logic nreset,
   input  logic nirq,
   input  logic naction_sti,
   input  logic naction_cli,
   input  logic nend,
   output logic fi,
   output logic nirqs
);

   logic ie;
   logic pend;
   logic irqs;
   logic ie_next;
   logic pend_next;
   logic irqs_next;

   // Next-state logic. CLI# is applied last so that it wins over both STI#
   // and a simultaneous request.
   always_comb begin
      ie_next   = ie;
      pend_next = pend;
      irqs_next = irqs;

      if (!naction_sti) ie_next = 1'b1;
      if (!naction_cli) ie_next = 1'b0;

      // A request is only remembered while interrupts are enabled. The enable
      // value used here is the one from before the edge, so a request on the
      // same edge as STI# is dropped.
      if (!nirq && ie)  pend_next = 1'b1;
      if (!naction_cli) pend_next = 1'b0;

      // END# enters service when the flag is set and leaves service when
      // already in service. If the microprogram omits CLI#, this keeps
      // toggling on every END#; that behaviour is intended.
      if (!nend) irqs_next = pend & ~irqs;
   end

   // State register. Reset forces the outputs to idle at once, even in the
   // middle of an interrupt service.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         ie   <= 1'b0;
         pend <= 1'b0;
         irqs <= 1'b0;
      end else begin
         ie   <= ie_next;
         pend <= pend_next;
         irqs <= irqs_next;
      end
   end

   // Both outputs come straight from flops, so no input reaches an output
   // combinationally.
   assign fi    = pend;
   assign nirqs = ~irqs;

endmodule

// File: tb/tb_interrupt_unit.sv
// tb_interrupt_unit: directed scoreboard bench for interrupt_unit.
// The driver pushes the expected {fi, nirqs} for each step. The monitor pops
// and compares the entries shortly after each rising edge, or after an
// asynchronous reset request.
module tb_interrupt_unit;

   logic clk = 1'b0;
   logic nreset;
   logic nirq;
   logic naction_sti;
   logic naction_cli;
   logic nend;
   logic fi;
   logic nirqs;

   logic [1:0] exp_q[$];
   string      name_q[$];
   int         total = 0;
   int         bad   = 0;
   logic       async_req = 1'b0;

   interrupt_unit dut (
      .clk         (clk),
      .nreset      (nreset),
      .nirq        (nirq),
      .naction_sti (naction_sti),
      .naction_cli (naction_cli),
      .nend        (nend),
      .fi          (fi),
      .nirqs       (nirqs)
   );

   // Clock generation: period 10, rising edges at 5, 15, 25, ...
   always #5 clk = ~clk;

   // Monitor: compares every queued expectation against the DUT outputs.
   initial begin
      logic [1:0] exp_v;
      logic [1:0] got_v;
      string      nm;
      forever begin
         @(posedge clk or async_req);
         #2;
         while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            nm    = name_q.pop_front();
            got_v = {fi, nirqs};
            total++;
            if (got_v !== exp_v) begin
               bad++;
               $display("FAIL %s: {fi,nirqs} got %b expected %b", nm, got_v, exp_v);
            end
         end
      end
   end

   // Driver: applies one set of inputs at the falling edge so they are stable
   // for the next rising edge. It queues the outputs expected after that edge
   // and then returns the inputs to idle.
   task automatic step(input logic a_nirq, input logic a_sti, input logic a_cli,
                       input logic a_end, input logic [1:0] exp_v, input string nm);
      @(negedge clk);
      nirq        = a_nirq;
      naction_sti = a_sti;
      naction_cli = a_cli;
      nend        = a_end;
      exp_q.push_back(exp_v);
      name_q.push_back(nm);
      @(posedge clk);
      #1;
      nirq        = 1'b1;
      naction_sti = 1'b1;
      naction_cli = 1'b1;
      nend        = 1'b1;
   endtask

   // Asserts the reset away from any clock edge and checks the outputs
   // before the next rising edge arrives.
   task automatic async_reset(input string nm);
      @(negedge clk);
      #2;
      nreset = 1'b0;
      exp_q.push_back(2'b01);
      name_q.push_back(nm);
      async_req = ~async_req;
      #2;
   endtask

   task automatic release_reset();
      @(negedge clk);
      nreset = 1'b1;
   endtask

   // Shorthand step kinds. The arguments are the expected fi and nirqs.
   task automatic do_idle(input logic efi, input logic enq, input string nm);
      step(1'b1, 1'b1, 1'b1, 1'b1, {efi, enq}, nm);
   endtask
   task automatic do_irq(input logic efi, input logic enq, input string nm);
      step(1'b0, 1'b1, 1'b1, 1'b1, {efi, enq}, nm);
   endtask
   task automatic do_sti(input logic efi, input logic enq, input string nm);
      step(1'b1, 1'b0, 1'b1, 1'b1, {efi, enq}, nm);
   endtask
   task automatic do_cli(input logic efi, input logic enq, input string nm);
      step(1'b1, 1'b1, 1'b0, 1'b1, {efi, enq}, nm);
   endtask
   task automatic do_end(input logic efi, input logic enq, input string nm);
      step(1'b1, 1'b1, 1'b1, 1'b0, {efi, enq}, nm);
   endtask

   // Main stimulus sequence.
   initial begin
      nreset      = 1'b0;
      nirq        = 1'b1;
      naction_sti = 1'b1;
      naction_cli = 1'b1;
      nend        = 1'b1;

      // Check the reset state while the reset is held.
      #1;
      exp_q.push_back(2'b01);
      name_q.push_back("reset_hold");
      async_req = ~async_req;
      repeat (2) @(posedge clk);
      release_reset();

      // Masking: requests without STI# are ignored.
      for (int i = 0; i < 10; i++) begin
         do_irq(1'b0, 1'b1, "mask_irq");
         do_idle(1'b0, 1'b1, "mask_idle");
      end

      // Normal sequence.
      do_sti(1'b0, 1'b1, "norm_sti");
      do_irq(1'b1, 1'b1, "norm_irq");
      do_end(1'b1, 1'b0, "norm_enter");
      do_cli(1'b0, 1'b0, "norm_cli");
      do_end(1'b0, 1'b1, "norm_leave");
      do_irq(1'b0, 1'b1, "norm_irq_masked");

      // Late request: it arrives after CLI# and is ignored.
      do_sti(1'b0, 1'b1, "late_sti");
      do_irq(1'b1, 1'b1, "late_irq");
      do_end(1'b1, 1'b0, "late_enter");
      do_cli(1'b0, 1'b0, "late_cli");
      do_irq(1'b0, 1'b0, "late_irq2");
      do_end(1'b0, 1'b1, "late_leave");

      // Early request: it arrives before CLI# and merges with the pending one.
      do_sti(1'b0, 1'b1, "early_sti");
      do_irq(1'b1, 1'b1, "early_irq");
      do_end(1'b1, 1'b0, "early_enter");
      do_irq(1'b1, 1'b0, "early_irq2");
      do_cli(1'b0, 1'b0, "early_cli");
      do_end(1'b0, 1'b1, "early_leave");

      // Toggle: END# without CLI# flips nirqs each time while fi stays set.
      do_sti(1'b0, 1'b1, "tog_sti");
      do_irq(1'b1, 1'b1, "tog_irq");
      for (int i = 0; i < 10; i++)
         do_end(1'b1, logic'(i % 2), "tog_end");
      do_cli(1'b0, 1'b1, "tog_cli");

      // Priority: CLI# beats STI#, and CLI# beats a request.
      step(1'b1, 1'b0, 1'b0, 1'b1, 2'b01, "prio_sti_cli");
      do_irq(1'b0, 1'b1, "prio_irq_masked");
      do_sti(1'b0, 1'b1, "prio_sti");
      step(1'b0, 1'b1, 1'b0, 1'b1, 2'b01, "prio_irq_cli");
      do_irq(1'b0, 1'b1, "prio_irq_after_cli");

      // Simultaneous END# and CLI#: enter service using the pre-edge fi.
      do_sti(1'b0, 1'b1, "endcli_sti");
      do_irq(1'b1, 1'b1, "endcli_irq");
      step(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, "endcli_both");
      do_end(1'b0, 1'b1, "endcli_leave");

      // Asynchronous reset in the middle of a service.
      do_sti(1'b0, 1'b1, "rst_sti");
      do_irq(1'b1, 1'b1, "rst_irq");
      do_end(1'b1, 1'b0, "rst_enter");
      async_reset("rst_async");
      release_reset();
      do_irq(1'b0, 1'b1, "rst_irq_masked");

      // Drain the queue, then report.
      @(posedge clk);
      #5;
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain: left %0d expected 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
